// File: rtl/vending_pkg.sv
// Shared types for the change dispenser: FSM states, coin values and one-hot coin codes.
// The one-hot code order matches money[2:0]: bit0 = 5, bit1 = 10, bit2 = 20.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CALC     = 3'd1,
    ST_SELECT   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_5    = 3'b001;
  localparam logic [2:0] SEL_10   = 3'b010;
  localparam logic [2:0] SEL_20   = 3'b100;

  function automatic logic [7:0] coin_value(input logic [2:0] sel);
    logic [7:0] val;
    case (sel)
      SEL_5:   val = VAL_5;
      SEL_10:  val = VAL_10;
      SEL_20:  val = VAL_20;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  // Largest coin that still fits in the remaining change and is in stock.
  function automatic logic [2:0] pick_coin(input logic [7:0] left, input logic [2:0] avail);
    logic [2:0] sel;
    sel = SEL_NONE;
    if (left >= VAL_20 && avail[2])      sel = SEL_20;
    else if (left >= VAL_10 && avail[1]) sel = SEL_10;
    else if (left >= VAL_5 && avail[0])  sel = SEL_5;
    return sel;
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination coin stock: loads INIT_* on reset, decrements on a granted coin,
// and reports which denominations are non-empty.
module coin_stock
  import vending_pkg::*;
#(
  parameter int INIT_COIN_5  = 8,
  parameter int INIT_COIN_10 = 8,
  parameter int INIT_COIN_20 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] take_i,
  output logic [2:0] avail_o
);

  logic [7:0] cnt5_q, cnt10_q, cnt20_q;

  // Counters stop at zero; the selector never asks for an empty denomination anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt5_q  <= 8'(INIT_COIN_5);
      cnt10_q <= 8'(INIT_COIN_10);
      cnt20_q <= 8'(INIT_COIN_20);
    end else begin
      if (take_i[0] && cnt5_q != 8'd0)  cnt5_q  <= cnt5_q - 8'd1;
      if (take_i[1] && cnt10_q != 8'd0) cnt10_q <= cnt10_q - 8'd1;
      if (take_i[2] && cnt20_q != 8'd0) cnt20_q <= cnt20_q - 8'd1;
    end
  end

  assign avail_o = {cnt20_q != 8'd0, cnt10_q != 8'd0, cnt5_q != 8'd0};

endmodule

// File: rtl/change_dispenser.sv
// Pays out sum_money - price one coin at a time over a req/ack handshake, largest first.
// Optional ack timeout with sticky fault: define DISPENSE_TIMEOUT_EN.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_COIN_5  = 8,
  parameter int INIT_COIN_10 = 8,
  parameter int INIT_COIN_20 = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_change,
  input  logic [7:0] sum_money,
  input  logic [7:0] price,
  input  logic       hopper_ack,
  output logic       coin_req,
  output logic [2:0] coin_sel,
  output logic       busy,
  output logic       done_change,
  output logic       short_change,
  output logic [7:0] change_left,
  output logic       fault
);

  state_e     state_q, state_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] price_q, price_d;
  logic [7:0] left_q, left_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] pick;
  logic [2:0] take;
  logic [2:0] avail;

  coin_stock #(
    .INIT_COIN_5  (INIT_COIN_5),
    .INIT_COIN_10 (INIT_COIN_10),
    .INIT_COIN_20 (INIT_COIN_20)
  ) u_stock (
    .clk     (clk),
    .reset   (reset),
    .take_i  (take),
    .avail_o (avail)
  );

  assign pick = pick_coin(left_q, avail);

`ifdef DISPENSE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= 8'd0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sum_q   <= 8'd0;
      price_q <= 8'd0;
      left_q  <= 8'd0;
      sel_q   <= SEL_NONE;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      price_q <= price_d;
      left_q  <= left_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    price_d = price_q;
    left_d  = left_q;
    sel_d   = sel_q;
    take    = SEL_NONE;
`ifdef DISPENSE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_change) begin
          sum_d   = sum_money;
          price_d = price;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        left_d  = (sum_q < price_q) ? 8'd0 : sum_q - price_q;
        state_d = ST_SELECT;
      end
      ST_SELECT: begin
        sel_d   = pick;
        state_d = (pick != SEL_NONE) ? ST_WAIT_ACK : ST_DONE;
`ifdef DISPENSE_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      ST_WAIT_ACK: begin
        if (hopper_ack) begin
          take    = sel_q;
          left_d  = left_q - coin_value(sel_q);
          sel_d   = SEL_NONE;
          state_d = ST_GAP;
        end
`ifdef DISPENSE_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          sel_d   = SEL_NONE;
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_GAP:   state_d = ST_SELECT;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign coin_req     = (state_q == ST_WAIT_ACK);
  assign coin_sel     = sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign done_change  = (state_q == ST_DONE);
  assign short_change = (state_q == ST_DONE) && (left_q != 8'd0);
  assign change_left  = left_q;
`ifdef DISPENSE_TIMEOUT_EN
  assign fault        = (state_q == ST_FAULT);
`else
  assign fault        = 1'b0;
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the coin hopper after a vending transaction completes.
- Takes the inserted total and the item price from the control path and computes change = sum_money - price.
- Pays the change out one coin at a time over a req/ack handshake, largest denomination first, tracking per-denomination coin stock.
- Sits between the vending control block and the physical hopper interface.

Parameters:
- INIT_COIN_5, 8, coins of value 5 loaded into stock at reset
- INIT_COIN_10, 8, coins of value 10 loaded at reset
- INIT_COIN_20, 4, coins of value 20 loaded at reset
- ACK_TIMEOUT, 255, cycles allowed in WAIT_ACK before fault (used only with DISPENSE_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start_change  in  1  one-cycle pulse: transaction done, dispense change
- sum_money  in  8  total inserted, sampled on start_change
- price  in  8  item price, sampled on start_change
- hopper_ack  in  1  hopper has ejected the requested coin; one-cycle pulse
- coin_req  out  1  request one coin; held until ack
- coin_sel  out  3  one-hot denomination: bit0 = 5, bit1 = 10, bit2 = 20 (matches money encoding)
- busy  out  1  high from the cycle after accepted start_change until done_change
- done_change  out  1  one-cycle pulse when dispensing ends
- short_change  out  1  valid with done_change; change could not be fully paid
- change_left  out  8  remaining unpaid change; live value
- fault  out  1  sticky hopper fault (timeout); cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Stock counters (8-bit each) load their INIT_* values.
  - Reset overrides any in-flight request: coin_req is low the cycle after reset is sampled.
- IDLE:
  - start_change=1 latches the inputs and goes to CALC.
  - If sum_money < price, change = 0.
  - start_change is ignored in every state other than IDLE, and while fault=1.
- CALC (1 cycle): change_left <= sum_money - price (8-bit, no wrap given the guard above). Go to SELECT.
- SELECT (1 cycle): pick the denomination greedily, in this order:
  - 20, if change_left >= 20 and stock20 > 0;
  - else 10, if change_left >= 10 and stock10 > 0;
  - else 5, if change_left >= 5 and stock5 > 0.
  - If a denomination is picked: drive coin_sel and go to WAIT_ACK.
  - If nothing is picked: go to DONE.
- WAIT_ACK:
  - coin_req=1; coin_sel held stable.
  - On hopper_ack: coin_req drops next cycle, change_left -= value, that stock counter decrements, then go to GAP.
  - hopper_ack outside WAIT_ACK is ignored.
- GAP (1 cycle, coin_req=0): return to SELECT.
  - Guarantees at least one idle cycle between coin requests.
- DONE (1 cycle):
  - done_change=1.
  - short_change = (change_left != 0). This covers a residue that is not a multiple of 5 as well as depleted stock.
  - busy=0 from the next cycle; return to IDLE. change_left holds until the next CALC.
- Latency:
  - start_change at cycle t gives busy=1 from t+1 and coin_req=1 at t+3.
  - Zero change gives done_change at t+3.
- Stock counters saturate at 0 and never underflow; selection already excludes an empty denomination.

Optional Feature:
- DISPENSE_TIMEOUT_EN defined:
  - A 8-bit counter runs in WAIT_ACK.
  - After ACK_TIMEOUT cycles without hopper_ack: go to FAULT and assert fault.
  - In FAULT: coin_req=0 and busy=1; exit only by reset.
  - change_left and stock are frozen.
- Not defined: WAIT_ACK waits indefinitely, the counter logic is absent, and fault is tied to 0.

Decomposition:
- Shared package (vending_pkg):
  - state encoding localparams;
  - denomination values 5/10/20;
  - one-hot coin_sel codes, aligned with the existing money[2:0] bit order.
- One natural sub-module: coin_stock, holding three counters with load-on-reset and decrement-on-grant.
  - It exports nonzero flags to the selector.

Test Plan:
- sum=35, price=15 → coins 20 then none left; one req; done_change with short_change=0, change_left=0; stock20 = 3.
- sum=50, price=15 → coin_sel sequence 20, 10, 5; three ack handshakes each separated by a GAP cycle; short_change=0.
- stock20 preset 0 (INIT_COIN_20=0), sum=40, price=0 → 10, 10, 10, 10; no 20 requested.
- sum=10, price=15 → done_change 3 cycles after start with change_left=0, no coin_req.
- start_change pulsed during WAIT_ACK → ignored; reset asserted in WAIT_ACK → coin_req=0 next cycle and stocks restored to INIT.
- With DISPENSE_TIMEOUT_EN and ACK_TIMEOUT=10: withhold ack → fault=1 after 10 cycles, coin_req=0, further start_change ignored.
